// File: rtl/peripheral_spram_ahb_initiator_if.sv
// AHB-Lite master/slave signal bundle for the SPRAM AHB initiator.
// The master modport is driven by the initiator, the slave modport by the target.
interface peripheral_spram_ahb_initiator_if #(
   parameter int unsigned PLEN = 8,
   parameter int unsigned XLEN = 32
);
   logic [PLEN-1:0] HADDR;
   logic            HWRITE;
   logic [2:0]      HSIZE;
   logic [2:0]      HBURST;
   logic [3:0]      HPROT;
   logic [1:0]      HTRANS;
   logic            HMASTLOCK;
   logic [XLEN-1:0] HWDATA;
   logic [XLEN-1:0] HRDATA;
   logic            HREADY;
   logic            HRESP;

   modport master (
      output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/peripheral_spram_ahb_initiator.sv
// Single-transfer AHB-Lite initiator with a two-slot (address/data) pipeline,
// two-cycle error handling and in-order responses for a simple request port.
module peripheral_spram_ahb_initiator #(
   parameter int unsigned PLEN      = 8,
   parameter int unsigned XLEN      = 32,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic                              HCLK,
   input  logic                              HRESET,
   input  logic                              req_i,
   input  logic                              we_i,
   input  logic [PLEN-1:0]                   addr_i,
   input  logic [2:0]                        size_i,
   input  logic [XLEN-1:0]                   wdata_i,
   output logic                              gnt_o,
   output logic                              rsp_valid_o,
   output logic                              rsp_err_o,
   output logic [XLEN-1:0]                   rsp_rdata_o,
   peripheral_spram_ahb_initiator_if.master  ahb
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_PIPE = 3'd2,
      ST_DATA = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // A request is unusable if it is wider than the bus or not naturally aligned.
   function automatic logic req_bad_f(input logic [PLEN-1:0] addr, input logic [2:0] size);
      logic [31:0]     bits_v;
      logic [PLEN-1:0] mask_v;
      bits_v    = 32'd8 << size;
      mask_v    = ~({PLEN{1'b1}} << size);
      req_bad_f = (bits_v > XLEN) || ((addr & mask_v) != {PLEN{1'b0}});
   endfunction

   state_t          state_r;
   state_t          state_nx_s;

   logic            a_valid_r;
   logic            a_bad_r;
   logic [XLEN-1:0] a_wdata_r;
   logic            d_valid_r;
   logic            d_bad_r;
   logic            d_we_r;

   logic [PLEN-1:0] haddr_r;
   logic            hwrite_r;
   logic [2:0]      hsize_r;
   logic [1:0]      htrans_r;
   logic [XLEN-1:0] hwdata_r;

   logic            rsp_valid_r;
   logic            rsp_err_r;
   logic [XLEN-1:0] rsp_rdata_r;

   logic            in_err_s;
   logic            first_err_s;
   logic            d_retire_s;
   logic            d_free_s;
   logic            a_adv_s;
   logic            gnt_s;
   logic            accept_s;
   logic            req_bad_s;
   logic            a_valid_nx_s;
   logic            a_bad_nx_s;
   logic            d_valid_nx_s;
   logic            err_nx_s;
   logic            rsp_err_nx_s;
   logic            rd_capture_s;
   logic [1:0]      htrans_nx_s;

   // State register of the pipeline FSM.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Slot movement, grant, next state and next bus transfer type.
   always_comb begin
      in_err_s     = 1'b0;
      first_err_s  = 1'b0;
      d_retire_s   = 1'b0;
      d_free_s     = 1'b0;
      a_adv_s      = 1'b0;
      gnt_s        = 1'b0;
      accept_s     = 1'b0;
      req_bad_s    = 1'b0;
      a_valid_nx_s = 1'b0;
      a_bad_nx_s   = 1'b0;
      d_valid_nx_s = 1'b0;
      err_nx_s     = 1'b0;
      rsp_err_nx_s = 1'b0;
      rd_capture_s = 1'b0;
      htrans_nx_s  = HTRANS_IDLE;
      state_nx_s   = ST_IDLE;

      in_err_s    = (state_r == ST_ERR);
      first_err_s = d_valid_r && !d_bad_r && !in_err_s && ahb.HRESP && !ahb.HREADY;
      // A rejected request never reached the bus, so nothing on the bus holds it back.
      d_retire_s  = d_valid_r && (d_bad_r || ahb.HREADY);
      d_free_s    = !d_valid_r || d_retire_s;
      a_adv_s     = a_valid_r && !in_err_s && d_free_s && (a_bad_r || ahb.HREADY);

      gnt_s     = !HRESET && !in_err_s && !first_err_s && (!a_valid_r || ahb.HREADY);
      accept_s  = req_i && gnt_s;
      req_bad_s = req_bad_f(addr_i, size_i);

      a_valid_nx_s = accept_s || (a_valid_r && !a_adv_s);
      d_valid_nx_s = a_adv_s || (d_valid_r && !d_retire_s);
      err_nx_s     = first_err_s || (in_err_s && !ahb.HREADY);

      if (accept_s) begin
         a_bad_nx_s = req_bad_s;
      end else begin
         a_bad_nx_s = a_bad_r;
      end

      rsp_err_nx_s = d_retire_s && (d_bad_r || in_err_s || ahb.HRESP);
      rd_capture_s = d_retire_s && !d_bad_r && !d_we_r && !in_err_s && !ahb.HRESP;

      if (err_nx_s) begin
         state_nx_s = ST_ERR;
      end else begin
         case ({a_valid_nx_s, d_valid_nx_s})
            2'b10:   state_nx_s = ST_ADDR;
            2'b11:   state_nx_s = ST_PIPE;
            2'b01:   state_nx_s = ST_DATA;
            default: state_nx_s = ST_IDLE;
         endcase
      end

      // The pending address is cancelled on the bus for the whole error sequence.
      if (a_valid_nx_s && !a_bad_nx_s && !err_nx_s) begin
         htrans_nx_s = HTRANS_NONSEQ;
      end else begin
         htrans_nx_s = HTRANS_IDLE;
      end
   end

   // Address/data slot contents and registered AHB master outputs.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         a_valid_r <= 1'b0;
         a_bad_r   <= 1'b0;
         a_wdata_r <= {XLEN{1'b0}};
         d_valid_r <= 1'b0;
         d_bad_r   <= 1'b0;
         d_we_r    <= 1'b0;
         haddr_r   <= {PLEN{1'b0}};
         hwrite_r  <= 1'b0;
         hsize_r   <= 3'b000;
         htrans_r  <= HTRANS_IDLE;
         hwdata_r  <= {XLEN{1'b0}};
      end else begin
         a_valid_r <= a_valid_nx_s;
         a_bad_r   <= a_bad_nx_s;
         d_valid_r <= d_valid_nx_s;
         htrans_r  <= htrans_nx_s;
         if (accept_s) begin
            a_wdata_r <= wdata_i;
            if (!req_bad_s) begin
               haddr_r  <= addr_i;
               hwrite_r <= we_i;
               hsize_r  <= size_i;
            end
         end
         if (a_adv_s) begin
            d_bad_r <= a_bad_r;
            d_we_r  <= hwrite_r;
            if (!a_bad_r) begin
               hwdata_r <= a_wdata_r;
            end
         end
      end
   end

   // Response pulse, error flag and read data captured at retire.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= {XLEN{1'b0}};
      end else begin
         rsp_valid_r <= d_retire_s;
         rsp_err_r   <= rsp_err_nx_s;
         if (rd_capture_s) begin
            rsp_rdata_r <= ahb.HRDATA;
         end
      end
   end

   assign gnt_o         = gnt_s;
   assign rsp_valid_o   = rsp_valid_r;
   assign rsp_err_o     = rsp_err_r;
   assign rsp_rdata_o   = rsp_rdata_r;

   assign ahb.HADDR     = haddr_r;
   assign ahb.HWRITE    = hwrite_r;
   assign ahb.HSIZE     = hsize_r;
   assign ahb.HTRANS    = htrans_r;
   assign ahb.HWDATA    = hwdata_r;
   assign ahb.HBURST    = 3'b000;
   assign ahb.HPROT     = HPROT_VAL;
   assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_spram_ahb_initiator.sv
// Directed bench for peripheral_spram_ahb_initiator: drives the request port and a
// scripted AHB slave on the falling edge, checks outputs just after it.
module tb_peripheral_spram_ahb_initiator;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        req_i;
   logic        we_i;
   logic [7:0]  addr_i;
   logic [2:0]  size_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rsp_valid_o;
   logic        rsp_err_o;
   logic [31:0] rsp_rdata_o;

   int errors = 0;
   int checks = 0;

   peripheral_spram_ahb_initiator_if #(.PLEN(8), .XLEN(32)) bus ();

   peripheral_spram_ahb_initiator #(.PLEN(8), .XLEN(32), .HPROT_VAL(4'b0011)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .size_i      (size_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_rdata_o (rsp_rdata_o),
      .ahb         (bus)
   );

   always #5 HCLK = ~HCLK;

   task automatic test_reset();
      HRESET = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 8'h00; size_i = 3'd0; wdata_i = 32'h0;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK); #1;
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b expected 0", gnt_o); end
      checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b expected 00", bus.HTRANS); end
      checks++; if (bus.HADDR !== 8'h00) begin errors++; $display("FAIL rst_haddr: got %h expected 00", bus.HADDR); end
      checks++; if (bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'd0) begin errors++; $display("FAIL rst_hwrite_hsize: got %b/%0d expected 0/0", bus.HWRITE, bus.HSIZE); end
      checks++; if (bus.HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h expected 0", bus.HWDATA); end
      checks++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rsp: got v=%b e=%b d=%h expected 0/0/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      checks++; if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011 || bus.HMASTLOCK !== 1'b0) begin errors++; $display("FAIL rst_const: got burst=%b prot=%b lock=%b expected 000/0011/0", bus.HBURST, bus.HPROT, bus.HMASTLOCK); end
      @(negedge HCLK); HRESET = 1'b0; req_i = 1'b0; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_release_gnt: got %b expected 1", gnt_o); end
   endtask

   task automatic test_single_write();
      @(negedge HCLK); req_i = 1'b1; we_i = 1'b1; addr_i = 8'h10; size_i = 3'd2; wdata_i = 32'hDEADBEEF; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b expected 1", gnt_o); end
      @(negedge HCLK); req_i = 1'b0; #1;
      checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h10) begin errors++; $display("FAIL wr_addr_phase: got %b/%h expected 10/10", bus.HTRANS, bus.HADDR); end
      checks++; if (bus.HWRITE !== 1'b1 || bus.HSIZE !== 3'd2) begin errors++; $display("FAIL wr_ctrl: got %b/%0d expected 1/2", bus.HWRITE, bus.HSIZE); end
      @(negedge HCLK); #1;
      checks++; if (bus.HWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hwdata: got %h expected deadbeef", bus.HWDATA); end
      checks++; if (bus.HTRANS !== 2'b00 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_data_phase: got htrans=%b v=%b expected 00/0", bus.HTRANS, rsp_valid_o); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL wr_rsp: got v=%b e=%b expected 1/0", rsp_valid_o, rsp_err_o); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b expected 0", rsp_valid_o); end
   endtask

   task automatic test_read_wait();
      @(negedge HCLK); req_i = 1'b1; we_i = 1'b0; addr_i = 8'h04; size_i = 3'd2; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rdw_gnt: got %b expected 1", gnt_o); end
      @(negedge HCLK); req_i = 1'b0; #1;
      checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h04 || bus.HWRITE !== 1'b0) begin errors++; $display("FAIL rdw_addr_phase: got %b/%h/%b expected 10/04/0", bus.HTRANS, bus.HADDR, bus.HWRITE); end
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK); bus.HREADY = 1'b0; #1;
         checks++; if (rsp_valid_o !== 1'b0 || bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rdw_wait%0d: got v=%b htrans=%b expected 0/00", i, rsp_valid_o, bus.HTRANS); end
      end
      @(negedge HCLK); bus.HREADY = 1'b1; bus.HRDATA = 32'h12345678; #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_early: got %b expected 0", rsp_valid_o); end
      @(negedge HCLK); bus.HRDATA = 32'h00000000; #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h12345678) begin errors++; $display("FAIL rdw_rsp: got v=%b e=%b d=%h expected 1/0/12345678", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_pulse: got %b expected 0", rsp_valid_o); end
   endtask

   task automatic test_back_to_back();
      @(negedge HCLK); req_i = 1'b1; we_i = 1'b1; addr_i = 8'h00; size_i = 3'd2; wdata_i = 32'h11111111; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b expected 1", gnt_o); end
      @(negedge HCLK); we_i = 1'b0; addr_i = 8'h00; #1;
      checks++; if (gnt_o !== 1'b1 || bus.HTRANS !== 2'b10 || bus.HWRITE !== 1'b1) begin errors++; $display("FAIL b2b_c1: got gnt=%b htrans=%b hwrite=%b expected 1/10/1", gnt_o, bus.HTRANS, bus.HWRITE); end
      @(negedge HCLK); we_i = 1'b1; addr_i = 8'h04; wdata_i = 32'h33333333; #1;
      checks++; if (gnt_o !== 1'b1 || bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h00 || bus.HWRITE !== 1'b0) begin errors++; $display("FAIL b2b_c2: got gnt=%b htrans=%b haddr=%h hwrite=%b expected 1/10/00/0", gnt_o, bus.HTRANS, bus.HADDR, bus.HWRITE); end
      checks++; if (bus.HWDATA !== 32'h11111111) begin errors++; $display("FAIL b2b_hwdata0: got %h expected 11111111", bus.HWDATA); end
      @(negedge HCLK); req_i = 1'b0; bus.HRDATA = 32'hCAFEF00D; #1;
      checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h04 || bus.HWRITE !== 1'b1) begin errors++; $display("FAIL b2b_c3: got htrans=%b haddr=%h hwrite=%b expected 10/04/1", bus.HTRANS, bus.HADDR, bus.HWRITE); end
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL b2b_rsp0: got v=%b e=%b expected 1/0", rsp_valid_o, rsp_err_o); end
      @(negedge HCLK); bus.HRDATA = 32'hBADBAD00; #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rsp1: got v=%b d=%h expected 1/cafef00d", rsp_valid_o, rsp_rdata_o); end
      checks++; if (bus.HWDATA !== 32'h33333333 || bus.HTRANS !== 2'b00) begin errors++; $display("FAIL b2b_c4: got hwdata=%h htrans=%b expected 33333333/00", bus.HWDATA, bus.HTRANS); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rsp2: got v=%b e=%b d=%h expected 1/0/cafef00d", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b expected 0", rsp_valid_o); end
   endtask

   task automatic test_error();
      @(negedge HCLK); req_i = 1'b1; we_i = 1'b0; addr_i = 8'h08; size_i = 3'd2; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL err_gnt0: got %b expected 1", gnt_o); end
      @(negedge HCLK); we_i = 1'b1; addr_i = 8'h0C; wdata_i = 32'hA5A5A5A5; #1;
      checks++; if (gnt_o !== 1'b1 || bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h08) begin errors++; $display("FAIL err_c1: got gnt=%b htrans=%b haddr=%h expected 1/10/08", gnt_o, bus.HTRANS, bus.HADDR); end
      @(negedge HCLK); req_i = 1'b0; bus.HRESP = 1'b1; bus.HREADY = 1'b0; #1;
      checks++; if (gnt_o !== 1'b0 || bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h0C) begin errors++; $display("FAIL err_first: got gnt=%b htrans=%b haddr=%h expected 0/10/0c", gnt_o, bus.HTRANS, bus.HADDR); end
      @(negedge HCLK); bus.HREADY = 1'b1; #1;
      checks++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 8'h0C || gnt_o !== 1'b0) begin errors++; $display("FAIL err_state: got htrans=%b haddr=%h gnt=%b expected 00/0c/0", bus.HTRANS, bus.HADDR, gnt_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", rsp_valid_o); end
      @(negedge HCLK); bus.HRESP = 1'b0; #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL err_rsp: got v=%b e=%b expected 1/1", rsp_valid_o, rsp_err_o); end
      checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h0C || bus.HWRITE !== 1'b1) begin errors++; $display("FAIL err_reissue: got %b/%h/%b expected 10/0c/1", bus.HTRANS, bus.HADDR, bus.HWRITE); end
      @(negedge HCLK); #1;
      checks++; if (bus.HWDATA !== 32'hA5A5A5A5 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL err_wdata: got %h v=%b expected a5a5a5a5/0", bus.HWDATA, rsp_valid_o); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL err_wr_rsp: got v=%b e=%b expected 1/0", rsp_valid_o, rsp_err_o); end
   endtask

   task automatic test_single_cycle_error();
      @(negedge HCLK); req_i = 1'b1; we_i = 1'b0; addr_i = 8'h14; size_i = 3'd2; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL sce_gnt: got %b expected 1", gnt_o); end
      @(negedge HCLK); req_i = 1'b0; #1;
      checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h14) begin errors++; $display("FAIL sce_addr: got %b/%h expected 10/14", bus.HTRANS, bus.HADDR); end
      @(negedge HCLK); bus.HRESP = 1'b1; bus.HREADY = 1'b1; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL sce_gnt_d: got %b expected 1", gnt_o); end
      @(negedge HCLK); bus.HRESP = 1'b0; #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL sce_rsp: got v=%b e=%b expected 1/1", rsp_valid_o, rsp_err_o); end
      @(negedge HCLK); #1;
      checks++; if (gnt_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL sce_after: got gnt=%b v=%b expected 1/0", gnt_o, rsp_valid_o); end
   endtask

   task automatic test_misaligned();
      logic [7:0] m_addr [2];
      logic [2:0] m_size [2];
      m_addr[0] = 8'h02; m_size[0] = 3'd2;
      m_addr[1] = 8'h00; m_size[1] = 3'd3;
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK); req_i = 1'b1; we_i = 1'b0; addr_i = m_addr[i]; size_i = m_size[i]; #1;
         checks++; if (gnt_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mis%0d_gnt: got gnt=%b v=%b expected 1/0", i, gnt_o, rsp_valid_o); end
         @(negedge HCLK); req_i = 1'b0; #1;
         checks++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 8'h14) begin errors++; $display("FAIL mis%0d_bus: got htrans=%b haddr=%h expected 00/14", i, bus.HTRANS, bus.HADDR); end
         @(negedge HCLK); #1;
         checks++; if (bus.HTRANS !== 2'b00 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mis%0d_d: got htrans=%b v=%b expected 00/0", i, bus.HTRANS, rsp_valid_o); end
         @(negedge HCLK); #1;
         checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL mis%0d_rsp: got v=%b e=%b expected 1/1", i, rsp_valid_o, rsp_err_o); end
      end
   endtask

   task automatic test_reset_mid_pipe();
      @(negedge HCLK); req_i = 1'b1; we_i = 1'b1; addr_i = 8'h20; size_i = 3'd2; wdata_i = 32'h5A5A5A5A; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rmp_gnt0: got %b expected 1", gnt_o); end
      @(negedge HCLK); we_i = 1'b0; addr_i = 8'h24; #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rmp_gnt1: got %b expected 1", gnt_o); end
      @(negedge HCLK); req_i = 1'b0; HRESET = 1'b1; #1;
      checks++; if (gnt_o !== 1'b0 || bus.HTRANS !== 2'b10 || bus.HADDR !== 8'h24) begin errors++; $display("FAIL rmp_pipe: got gnt=%b htrans=%b haddr=%h expected 0/10/24", gnt_o, bus.HTRANS, bus.HADDR); end
      @(negedge HCLK); HRESET = 1'b0; #1;
      checks++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 8'h00 || bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'd0) begin errors++; $display("FAIL rmp_bus: got %b/%h/%b/%0d expected 00/00/0/0", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE); end
      checks++; if (bus.HWDATA !== 32'h0 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rmp_rsp: got hwdata=%h v=%b e=%b d=%h expected 0/0/0/0", bus.HWDATA, rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rmp_gnt_after: got %b expected 1", gnt_o); end
      @(negedge HCLK); #1;
      checks++; if (rsp_valid_o !== 1'b0 || bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rmp_quiet: got v=%b htrans=%b expected 0/00", rsp_valid_o, bus.HTRANS); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_back_to_back();
      test_error();
      test_single_cycle_error();
      test_misaligned();
      test_reset_mid_pipe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
